pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Generates stall and flush controls for PC, IF/ID and ID/EX from three sources:
  - load-use hazards;
  - taken branches and jumps resolved in EX;
  - a multi-cycle mult/div unit (MDU) that occupies HI/LO for a fixed latency.
- Sits beside the decode stage. Drives ID_Ex_flush into the ID/EX register and stall/flush into PC and IF/ID.

Parameters:
- MULT_CYCLES, 4: MDU busy cycles for mult/multu; legal range 1..63.
- DIV_CYCLES, 32: MDU busy cycles for div/divu; legal range 1..63.

Ports:
- clk  in  1  pipeline clock; state updates on posedge.
- rst  in  1  synchronous, active-low reset; sampled on posedge clk.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_useRs  in  1  ID instruction reads rs.
- ID_useRt  in  1  ID instruction reads rt.
- ID_mdu_start  in  1  ID instruction is mult/multu/div/divu.
- ID_mdu_div  in  1  with ID_mdu_start: 1=div, 0=mult.
- ID_mdu_read  in  1  ID instruction is mfhi/mflo/mthi/mtlo.
- Ex_MemRead  in  1  EX instruction is a load.
- Ex_RegWr  in  1  EX instruction writes a register.
- Ex_Rt  in  5  load destination in EX.
- Ex_redirect  in  1  taken branch or jump resolved in EX this cycle.
- pc_stall  out  1  hold PC.
- IF_ID_stall  out  1  hold the IF/ID register.
- IF_ID_flush  out  1  clear IF/ID to a nop.
- ID_Ex_flush  out  1  insert a bubble into ID/EX.
- mdu_go  out  1  one-cycle start strobe to the MDU.
- mdu_busy  out  1  MDU operation in flight.
- mdu_done  out  1  one-cycle pulse in the final busy cycle.
- stall_cycles  out  32  count of stall cycles (see Optional Feature).
- flush_cycles  out  32  count of redirect flushes (see Optional Feature).

Behaviour:
- FSM states: IDLE, BUSY. Registered: state, 6-bit down-counter cnt.
- Internal terms, all combinational:
  - load_use = Ex_MemRead & Ex_RegWr & (Ex_Rt != 0) & ((ID_useRs & ID_Rs == Ex_Rt) | (ID_useRt & ID_Rt == Ex_Rt)).
  - mdu_hz = (state == BUSY) & (ID_mdu_read | ID_mdu_start) & !(cnt == 0).
  - stall = !Ex_redirect & (load_use | mdu_hz).
- Output priority:
  1. Ex_redirect: IF_ID_flush=1, ID_Ex_flush=1, pc_stall=0, IF_ID_stall=0. The redirect overrides any stall that cycle.
  2. stall: pc_stall=1, IF_ID_stall=1, ID_Ex_flush=1, IF_ID_flush=0.
  3. Otherwise all four outputs are 0.
- Latency:
  - Stall and flush outputs are combinational, valid in the same cycle as the inputs.
  - A load-use hazard yields exactly one bubble, because the load leaves EX the next cycle.
- MDU accept: accept = ID_mdu_start & !Ex_redirect & !stall & (state == IDLE or cnt == 0).
  - On accept: mdu_go=1 the same cycle.
  - Next posedge: state=BUSY, cnt = (ID_mdu_div ? DIV_CYCLES : MULT_CYCLES) - 1.
- BUSY:
  - mdu_busy=1.
  - cnt decrements each posedge.
  - When cnt==0: mdu_done=1 for that cycle; next state is IDLE, or BUSY reloaded if accept is asserted.
  - An HI/LO access in ID while cnt==0 proceeds without stall, i.e. back-to-back issue is allowed.
- An accepted MDU operation is never cancelled by a later redirect. Only reset aborts it.
- A rejected start (stall or redirect in the same cycle) produces no mdu_go and leaves state unchanged.
- Reset (rst==0 at posedge, including mid-operation):
  - state=IDLE, cnt=0, counters=0.
  - mdu_busy, mdu_done and mdu_go read 0 from the following cycle.
  - Stall/flush outputs still follow their combinational equations.
- Ex_Rt==0 never causes a stall.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - stall_cycles increments each cycle stall=1.
  - flush_cycles increments each cycle Ex_redirect=1.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on reset.
- Undefined: both ports are tied to 0 and no counter logic is built.

Test Plan:
- Load-use: Ex_MemRead=1, Ex_RegWr=1, Ex_Rt=5, ID_Rs=5, ID_useRs=1 -> pc_stall, IF_ID_stall and ID_Ex_flush each =1 for exactly 1 cycle; with Ex_Rt=0 -> all 0.
- Redirect beats stall: same load_use inputs plus Ex_redirect=1 -> IF_ID_flush=1, ID_Ex_flush=1, pc_stall=0; flush_cycles +1 and stall_cycles unchanged (HAZARD_PERF_EN).
- Mult then mfhi: ID_mdu_start=1, ID_mdu_div=0 -> mdu_go pulse; mdu_busy for 4 cycles. mfhi held in ID stalls 3 cycles and proceeds in the mdu_done cycle.
- Div busy plus branch: start div, then Ex_redirect during BUSY -> mdu_busy stays 1 for all 32 cycles; mdu_done fires once.
- Start blocked: ID_mdu_start with load_use=1 -> no mdu_go and state stays IDLE; start retried next cycle -> accepted.
- Reset mid-div: rst=0 at busy cycle 10 -> next cycle mdu_busy=0, cnt=0, counters=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : stall/flush controller beside the decode stage: load-use, EX redirects, and the MDU busy window.
// Latency : stall/flush/mdu_go are combinational in the cycle of the inputs; MDU state updates on posedge clk.
// Backpres: a stall holds PC and IF/ID and bubbles ID/EX. A redirect overrides any stall in the same cycle.
//
// Ports:
//   clk, rst              pipeline clock; synchronous active-low reset
//   ID_*                  operand use/fields and MDU class of the instruction in decode
//   Ex_MemRead/RegWr/Rt   load in EX (load-use detection)
//   Ex_redirect           taken branch/jump resolved in EX
//   pc_stall, IF_ID_stall, IF_ID_flush, ID_Ex_flush   pipeline controls
//   mdu_go/busy/done      MDU start strobe, in-flight flag, final-cycle pulse
//   stall_cycles, flush_cycles  perf counters, built only when HAZARD_PERF_EN is defined (else tied to 0)
module pipe_hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_useRs,
    input  logic        ID_useRt,
    input  logic        ID_mdu_start,
    input  logic        ID_mdu_div,
    input  logic        ID_mdu_read,
    input  logic        Ex_MemRead,
    input  logic        Ex_RegWr,
    input  logic [4:0]  Ex_Rt,
    input  logic        Ex_redirect,
    output logic        pc_stall,
    output logic        IF_ID_stall,
    output logic        IF_ID_flush,
    output logic        ID_Ex_flush,
    output logic        mdu_go,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Counter holds (remaining busy cycles - 1), so the load value is latency - 1.
    localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

    logic [0:0] state;
    logic [5:0] cnt;

    logic load_use;
    logic mdu_hz;
    logic stall;
    logic cnt_zero;
    logic accept;

    assign cnt_zero = (cnt == 6'd0);

    // r0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = Ex_MemRead & Ex_RegWr & (Ex_Rt != 5'd0) &
                      ((ID_useRs & (ID_Rs == Ex_Rt)) | (ID_useRt & (ID_Rt == Ex_Rt)));

    // In the final busy cycle HI/LO is already valid, so access and back-to-back issue proceed.
    assign mdu_hz = (state == BUSY) & (ID_mdu_read | ID_mdu_start) & ~cnt_zero;

    assign stall  = ~Ex_redirect & (load_use | mdu_hz);

    assign accept = ID_mdu_start & ~Ex_redirect & ~stall & ((state == IDLE) | cnt_zero);

    always_comb begin
        pc_stall    = 1'b0;
        IF_ID_stall = 1'b0;
        IF_ID_flush = 1'b0;
        ID_Ex_flush = 1'b0;
        if (Ex_redirect) begin
            IF_ID_flush = 1'b1;
            ID_Ex_flush = 1'b1;
        end else if (stall) begin
            pc_stall    = 1'b1;
            IF_ID_stall = 1'b1;
            ID_Ex_flush = 1'b1;
        end
    end

    assign mdu_go   = accept;
    assign mdu_busy = (state == BUSY);
    assign mdu_done = (state == BUSY) & cnt_zero;

    // An accepted operation runs to completion; redirects never touch this state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else if (accept) begin
            state <= BUSY;
            cnt   <= ID_mdu_div ? DIV_LOAD : MULT_LOAD;
        end else if (state == BUSY) begin
            if (cnt_zero) begin
                state <= IDLE;
            end else begin
                cnt <= cnt - 6'd1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (stall)       stall_q <= stall_q + 32'd1;
            if (Ex_redirect) flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_cycles = flush_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose : self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a reference model.
// Latency : inputs change 1ns after posedge, outputs sampled at negedge, model state advances once per cycle.
// Backpres: n/a (bench); the model tracks MDU occupancy as "busy cycles remaining".
module tb_pipe_hazard_ctrl;

    localparam int MULT_CYCLES = 4;
    localparam int DIV_CYCLES  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_use_rs, id_use_rt, id_mdu_start, id_mdu_div, id_mdu_read;
    logic        ex_memread, ex_regwr, ex_redirect;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_flush;
    logic        mdu_go, mdu_busy, mdu_done;
    logic [31:0] stall_cycles, flush_cycles;

    pipe_hazard_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk          (clk),
        .rst          (rst),
        .ID_Rs        (id_rs),
        .ID_Rt        (id_rt),
        .ID_useRs     (id_use_rs),
        .ID_useRt     (id_use_rt),
        .ID_mdu_start (id_mdu_start),
        .ID_mdu_div   (id_mdu_div),
        .ID_mdu_read  (id_mdu_read),
        .Ex_MemRead   (ex_memread),
        .Ex_RegWr     (ex_regwr),
        .Ex_Rt        (ex_rt),
        .Ex_redirect  (ex_redirect),
        .pc_stall     (pc_stall),
        .IF_ID_stall  (if_id_stall),
        .IF_ID_flush  (if_id_flush),
        .ID_Ex_flush  (id_ex_flush),
        .mdu_go       (mdu_go),
        .mdu_busy     (mdu_busy),
        .mdu_done     (mdu_done),
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: number of MDU busy cycles still to go (0 = idle), plus perf totals.
    int          rem_busy = 0;
    logic [31:0] m_stalls = 32'd0;
    logic [31:0] m_flushes = 32'd0;

    // Last sampled DUT outputs, for scenario-level tallies.
    logic obs_go, obs_busy, obs_done, obs_pc_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rst          = 1'b1;
        id_rs        = 5'd0;
        id_rt        = 5'd0;
        ex_rt        = 5'd0;
        id_use_rs    = 1'b0;
        id_use_rt    = 1'b0;
        id_mdu_start = 1'b0;
        id_mdu_div   = 1'b0;
        id_mdu_read  = 1'b0;
        ex_memread   = 1'b0;
        ex_regwr     = 1'b0;
        ex_redirect  = 1'b0;
    endtask

    // Called 1ns after a posedge with inputs already set; checks this cycle, advances the model.
    task automatic tick();
        bit lu, hz, st, acc;
        #4;
        lu  = ex_memread && ex_regwr && (ex_rt != 0) &&
              ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt));
        hz  = (rem_busy > 1) && (id_mdu_read || id_mdu_start);
        st  = !ex_redirect && (lu || hz);
        acc = id_mdu_start && !ex_redirect && !st && (rem_busy <= 1);

        chk("pc_stall",    pc_stall,    st);
        chk("if_id_stall", if_id_stall, st);
        chk("if_id_flush", if_id_flush, ex_redirect);
        chk("id_ex_flush", id_ex_flush, ex_redirect || st);
        chk("mdu_go",      mdu_go,      acc);
        chk("mdu_busy",    mdu_busy,    rem_busy > 0);
        chk("mdu_done",    mdu_done,    rem_busy == 1);
`ifdef HAZARD_PERF_EN
        chk("stall_cycles", stall_cycles, m_stalls);
        chk("flush_cycles", flush_cycles, m_flushes);
`else
        chk("stall_cycles", stall_cycles, 32'd0);
        chk("flush_cycles", flush_cycles, 32'd0);
`endif
        obs_go       = mdu_go;
        obs_busy     = mdu_busy;
        obs_done     = mdu_done;
        obs_pc_stall = pc_stall;

        if (!rst) begin
            rem_busy  = 0;
            m_stalls  = 32'd0;
            m_flushes = 32'd0;
        end else begin
            if (acc)               rem_busy = id_mdu_div ? DIV_CYCLES : MULT_CYCLES;
            else if (rem_busy > 0) rem_busy = rem_busy - 1;
            if (st)          m_stalls  = m_stalls + 32'd1;
            if (ex_redirect) m_flushes = m_flushes + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] r);
        ex_memread = 1'b1;
        ex_regwr   = 1'b1;
        ex_rt      = r;
        id_rs      = 5'd5;
        id_use_rs  = 1'b1;
    endtask

    int n_busy, n_done, n_stall;

    initial begin
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state.
        tick();
        chk("reset_busy", obs_busy, 1'b0);

        // Load-use: one bubble, gone once the load leaves EX.
        set_load_use(5'd5);
        tick();
        chk("lu_stall", obs_pc_stall, 1'b1);
        idle_inputs();
        tick();
        chk("lu_one_bubble", obs_pc_stall, 1'b0);
        // Load into r0 never stalls.
        set_load_use(5'd0);
        id_rs = 5'd0;
        tick();
        chk("lu_r0", obs_pc_stall, 1'b0);

        // Redirect beats a simultaneous load-use.
        set_load_use(5'd5);
        ex_redirect = 1'b1;
        tick();
        chk("redir_no_stall", obs_pc_stall, 1'b0);
        idle_inputs();

        // Mult, then mfhi held in decode: 3 stalls, proceeds in the done cycle.
        id_mdu_start = 1'b1;
        tick();
        chk("mult_go", obs_go, 1'b1);
        idle_inputs();
        id_mdu_read = 1'b1;
        n_busy = 0; n_stall = 0; n_done = 0;
        for (int i = 0; i < MULT_CYCLES; i++) begin
            tick();
            n_busy  += int'(obs_busy);
            n_stall += int'(obs_pc_stall);
            n_done  += int'(obs_done);
        end
        chk("mult_busy_len", n_busy, MULT_CYCLES);
        chk("mfhi_stalls",   n_stall, MULT_CYCLES - 1);
        chk("mult_done_cnt", n_done, 1);
        idle_inputs();
        tick();
        chk("mult_idle", obs_busy, 1'b0);

        // Div with a redirect mid-flight: runs its full length, one done pulse.
        id_mdu_start = 1'b1;
        id_mdu_div   = 1'b1;
        tick();
        idle_inputs();
        n_busy = 0; n_done = 0;
        for (int i = 0; i < DIV_CYCLES + 2; i++) begin
            ex_redirect = (i == 5) || (i == 20);
            tick();
            n_busy += int'(obs_busy);
            n_done += int'(obs_done);
        end
        idle_inputs();
        chk("div_busy_len", n_busy, DIV_CYCLES);
        chk("div_done_cnt", n_done, 1);

        // Start blocked by load-use, then retried and accepted.
        set_load_use(5'd5);
        id_mdu_start = 1'b1;
        tick();
        chk("blocked_go", obs_go, 1'b0);
        idle_inputs();
        id_mdu_start = 1'b1;
        tick();
        chk("blocked_busy", obs_busy, 1'b0);
        chk("retry_go", obs_go, 1'b1);
        idle_inputs();
        for (int i = 0; i < MULT_CYCLES; i++) tick();

        // Reset in the middle of a div.
        id_mdu_start = 1'b1;
        id_mdu_div   = 1'b1;
        tick();
        idle_inputs();
        ex_redirect = 1'b1;
        tick();
        ex_redirect = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_busy", obs_busy, 1'b0);
        chk("rst_mid_done", obs_done, 1'b0);

        // Random traffic; small register set so hazards are frequent.
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 99) != 0);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_rt        = 5'($urandom_range(0, 3));
            id_use_rs    = 1'($urandom_range(0, 1));
            id_use_rt    = 1'($urandom_range(0, 1));
            ex_memread   = ($urandom_range(0, 2) == 0);
            ex_regwr     = ($urandom_range(0, 3) != 0);
            ex_redirect  = ($urandom_range(0, 7) == 0);
            id_mdu_start = ($urandom_range(0, 3) == 0);
            id_mdu_div   = ($urandom_range(0, 4) == 0);
            id_mdu_read  = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
